// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control sequencer.
// MULTICYCLE_CONTROL_FSM_ADDI_EN enables the ADDI path in the top.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_MEM_ADDR, S_MEM_RD,
        S_LW_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_ADDI_EX, S_ADDI_WB
    } state_t;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type function field to ALU operation; legal_o flags the supported funcs.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] func_i,
    output alu_op_t    alu_op_o,
    output logic       legal_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        legal_o  = 1'b1;
        case (func_i)
            FN_ADD:  alu_op_o = ALU_ADD;
            FN_SUB:  alu_op_o = ALU_SUB;
            FN_AND:  alu_op_o = ALU_AND;
            FN_OR:   alu_op_o = ALU_OR;
            FN_SLT:  alu_op_o = ALU_SLT;
            default: legal_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer: state register, instruction counter and state-decoded datapath controls.
// Defining MULTICYCLE_CONTROL_FSM_ADDI_EN makes opcode 8 (ADDI) a legal instruction.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    // LW/SW and BEQ/BNE share states; the distinction is latched in DECODE.
    logic             is_lw_q, is_lw_d;
    logic             is_bne_q, is_bne_d;
    alu_op_t          dec_op;
    logic             func_legal;
    logic             op_legal;

    mc_alu_decoder u_alu_dec (
        .func_i   (func),
        .alu_op_o (dec_op),
        .legal_o  (func_legal)
    );

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_RTYPE: op_legal = func_legal;
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: op_legal = 1'b1;
`ifdef MULTICYCLE_CONTROL_FSM_ADDI_EN
            OP_ADDI:  op_legal = 1'b1;
`endif
            default:  op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        is_lw_d  = is_lw_q;
        is_bne_d = is_bne_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                is_lw_d  = (opcode == OP_LW);
                is_bne_d = (opcode == OP_BNE);
                if (!op_legal) begin
                    state_d = S_FETCH;
                end else begin
                    case (opcode)
                        OP_RTYPE:     state_d = S_EXEC_R;
                        OP_LW, OP_SW: state_d = S_MEM_ADDR;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_ADDI_EX;
                    endcase
                end
            end
            S_EXEC_R:   state_d = S_R_WB;
            S_MEM_ADDR: state_d = is_lw_q ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_LW_WB;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            default:    state_d = S_FETCH;
        endcase
        count_d = count_q;
        if (state_d == S_FETCH && state_q != S_FETCH) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            count_q  <= '0;
            is_lw_q  <= 1'b0;
            is_bne_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_lw_q  <= is_lw_d;
            is_bne_q <= is_bne_d;
        end
    end

    assign instr_count = count_q;

    always_comb begin
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH;
                illegal_op = !op_legal;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = dec_op;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_LW_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = is_bne_q ? !zero : zero;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_JUMP;
            end
            S_ADDI_WB: reg_write = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (CNT_W=4 so the counter wrap is reachable).
module tb_multicycle_control_fsm;

    logic       clk, rst_n;
    logic [5:0] opcode, func;
    logic       zero, mem_ready;
    logic       iord, mem_read, mem_write, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a;
    logic [2:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [3:0] instr_count;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_cnt;

    multicycle_control_fsm #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step into FETCH: presents the instruction with mem_ready=1 and checks the fetch controls.
    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        func = fn;
        mem_ready = 1'b1;
        #1;
        chk("fetch_mem_read", mem_read, 1);
        chk("fetch_ir_write", ir_write, 1);
        chk("fetch_count", instr_count, exp_cnt);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0; func = 6'd0; zero = 1'b0;
        exp_cnt = 4'd0;
        #12;
        chk("rst_mem_read", mem_read, 1);
        chk("rst_iord", iord, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_mem_write", mem_write, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ir_write", ir_write, 1);
        chk("rel_pc_write", pc_write, 1);
        chk("rel_src_b", alu_src_b, 1);
        @(posedge clk); #1;

        // ADD: the release above already fetched it
        opcode = 6'd0; func = 6'd32; #1;
        chk("add_dec_src_b", alu_src_b, 3);
        chk("add_dec_illegal", illegal_op, 0);
        chk("add_dec_ir_write", ir_write, 0);
        tick();
        chk("add_ex_src_a", alu_src_a, 1);
        chk("add_ex_alu_op", alu_op, 0);
        chk("add_ex_src_b", alu_src_b, 0);
        tick();
        chk("add_wb_reg_write", reg_write, 1);
        chk("add_wb_reg_dst", reg_dst, 1);
        chk("add_wb_mem_to_reg", mem_to_reg, 0);
        chk("add_wb_count", instr_count, 0);
        tick();
        exp_cnt = 4'd1;

        // SLT
        fetch(6'd0, 6'd42);
        tick();
        chk("slt_ex_alu_op", alu_op, 4);
        tick(); tick();
        exp_cnt = 4'd2;

        // LW with a stalled fetch, then 3 wait cycles in MEM_RD
        mem_ready = 1'b0; #1;
        chk("fstall_ir_write", ir_write, 0);
        chk("fstall_pc_write", pc_write, 0);
        tick();
        chk("fstall_hold_src_b", alu_src_b, 1);
        chk("fstall_hold_read", mem_read, 1);
        fetch(6'd35, 6'd0);
        tick();
        chk("lw_ma_src_a", alu_src_a, 1);
        chk("lw_ma_src_b", alu_src_b, 2);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lw_rd_wait_read", mem_read, 1);
            chk("lw_rd_wait_iord", iord, 1);
        end
        tick();
        mem_ready = 1'b1; #1;
        chk("lw_rd_last_read", mem_read, 1);
        chk("lw_rd_last_iord", iord, 1);
        tick();
        chk("lw_wb_reg_write", reg_write, 1);
        chk("lw_wb_mem_to_reg", mem_to_reg, 1);
        chk("lw_wb_reg_dst", reg_dst, 0);
        tick();
        exp_cnt = 4'd3;

        // SW, zero wait
        fetch(6'd43, 6'd0);
        tick(); tick();
        chk("sw_wr_write", mem_write, 1);
        chk("sw_wr_read", mem_read, 0);
        chk("sw_wr_iord", iord, 1);
        tick();
        exp_cnt = 4'd4;

        // Branches
        fetch(6'd4, 6'd0);
        tick();
        zero = 1'b1; #1;
        chk("beq_z1_pc_write", pc_write, 1);
        chk("beq_pc_src", pc_src, 1);
        chk("beq_alu_op", alu_op, 1);
        tick();
        exp_cnt = 4'd5;
        fetch(6'd5, 6'd0);
        tick();
        zero = 1'b1; #1;
        chk("bne_z1_pc_write", pc_write, 0);
        tick();
        exp_cnt = 4'd6;
        fetch(6'd5, 6'd0);
        tick();
        zero = 1'b0; #1;
        chk("bne_z0_pc_write", pc_write, 1);
        tick();
        exp_cnt = 4'd7;

        // Illegal R-type func
        fetch(6'd0, 6'd7);
        chk("ill_func_pulse", illegal_op, 1);
        tick();
        chk("ill_func_back_fetch", mem_read, 1);
        chk("ill_func_pulse_end", illegal_op, 0);
        exp_cnt = 4'd8;

        // Opcode 8
        fetch(6'd8, 6'd0);
`ifdef MULTICYCLE_CONTROL_FSM_ADDI_EN
        chk("addi_dec_legal", illegal_op, 0);
        tick();
        chk("addi_ex_src_b", alu_src_b, 2);
        tick();
        chk("addi_wb_reg_write", reg_write, 1);
        chk("addi_wb_reg_dst", reg_dst, 0);
        tick();
`else
        chk("op8_illegal_pulse", illegal_op, 1);
        tick();
        chk("op8_back_fetch", alu_src_b, 1);
`endif
        exp_cnt = 4'd9;

        // Jumps through the counter wrap
        for (int i = 0; i < 7; i++) begin
            fetch(6'd2, 6'd0);
            tick();
            chk("j_pc_write", pc_write, 1);
            chk("j_pc_src", pc_src, 2);
            tick();
            exp_cnt = exp_cnt + 4'd1;
        end
        chk("wrap_count", instr_count, 0);

        // Reset while a store is waiting
        fetch(6'd43, 6'd0);
        tick();
        mem_ready = 1'b0;
        tick();
        chk("swr_write_wait", mem_write, 1);
        tick();
        chk("swr_write_hold", mem_write, 1);
        rst_n = 1'b0; #1;
        chk("swr_rst_write", mem_write, 0);
        chk("swr_rst_read", mem_read, 1);
        chk("swr_rst_count", instr_count, 0);
        chk("swr_rst_reg_write", reg_write, 0);
        rst_n = 1'b1;
        tick();
        chk("swr_after_fetch", alu_src_b, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
